// File: rtl/uart_fifo_bridge.sv
`timescale 1ns/1ps
// uart_fifo_bridge: RX and TX byte FIFOs sitting between the CPU-side serial
// address decoder and the async_receiver / async_transmitter pair. Received
// bytes are captured on the receiver's ready flag and acknowledged with a
// one-cycle clear pulse; queued bytes are fed to the transmitter through a
// start/busy handshake FSM with an anti-deadlock timeout.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rd_req_i,
  input  logic       wr_req_i,
  input  logic [7:0] wr_data_i,
  input  logic       stat_rd_i,
  output logic [7:0] rd_data_o,
  output logic [2:0] status_o,
  input  logic       rx_ready_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_clear_o,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // RX side
  // ---------------------------------------------------------------------------
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [AW:0]   rx_count;
  logic          rx_clear;
  logic          overrun;

  logic          rx_empty;
  logic          rx_full;
  logic          capture;
  logic          rx_pop;
  logic          rx_push;
  logic          ovr_set;

  // RX handshake decode: capture only when no clear pulse is in flight, so a
  // slowly falling ready flag is never taken twice.
  always_comb begin
    rx_empty = (rx_count == '0);
    rx_full  = (rx_count == FULL_CNT);
    capture  = rx_ready_i & ~rx_clear;
    rx_pop   = rd_req_i & ~rx_empty;
    // A pop in the same cycle frees the slot the new byte needs.
    rx_push  = capture & (~rx_full | rx_pop);
    ovr_set  = capture & rx_full & ~rx_pop;
  end

  // RX storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk_50M) begin
    if (!rst && rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data_i;
    end
  end

  // RX pointers, occupancy, clear pulse and sticky overrun flag.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rx_clear  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + 1'b1;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      rx_clear <= capture;
      // New overrun beats a simultaneous status read.
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (stat_rd_i) begin
        overrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX side
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [AW:0]   tx_count;
  logic [7:0]    tx_hold;

  tx_state_t     state;
  tx_state_t     state_next;
  logic [1:0]    wait_cnt;
  logic [1:0]    wait_cnt_next;
  logic          load_data;

  logic          tx_empty;
  logic          tx_full;
  logic          tx_pop;
  logic          tx_push;

  // TX FIFO decode; the FSM removes the head exactly in its START cycle.
  always_comb begin
    tx_empty = (tx_count == '0);
    tx_full  = (tx_count == FULL_CNT);
    tx_pop   = (state == START);
    tx_push  = wr_req_i & (~tx_full | tx_pop);
  end

  // TX storage array.
  always_ff @(posedge clk_50M) begin
    if (!rst && tx_push) begin
      tx_mem[tx_wr_ptr] <= wr_data_i;
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX handshake state, timeout counter and the byte presented to the
  // transmitter. The head is latched on the IDLE->START transition so it is
  // already valid during the START cycle, and is held until the next start.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_hold  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (load_data) begin
        tx_hold <= tx_mem[tx_rd_ptr];
      end
    end
  end

  // TX handshake next-state logic.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    load_data     = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          state_next = START;
          load_data  = 1'b1;
        end
      end
      START: begin
        state_next    = WAIT_BUSY;
        wait_cnt_next = '0;
      end
      WAIT_BUSY: begin
        // Give up waiting for busy after four cycles so a silent transmitter
        // cannot wedge the queue.
        if (tx_busy_i || (wait_cnt == 2'd3)) begin
          state_next = WAIT_DONE;
        end else begin
          wait_cnt_next = wait_cnt + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_o  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
    status_o   = {overrun, ~rx_empty, ~tx_full};
    rx_clear_o = rx_clear;
    tx_start_o = (state == START);
    tx_data_o  = tx_hold;
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
`timescale 1ns/1ps
// tb_uart_fifo_bridge: directed and randomized stimulus against a queue-based
// reference model of the bridge, with a simple transmitter model that raises
// busy one cycle after each start and holds it for a configurable time.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;

  logic       clk_50M;
  logic       rst;
  logic       rd_req_i;
  logic       wr_req_i;
  logic [7:0] wr_data_i;
  logic       stat_rd_i;
  logic [7:0] rd_data_o;
  logic [2:0] status_o;
  logic       rx_ready_i;
  logic [7:0] rx_data_i;
  logic       rx_clear_o;
  logic       tx_busy_i;
  logic       tx_start_o;
  logic [7:0] tx_data_o;

  uart_fifo_bridge #(.DEPTH(16), .AW(4)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .rd_req_i   (rd_req_i),
    .wr_req_i   (wr_req_i),
    .wr_data_i  (wr_data_i),
    .stat_rd_i  (stat_rd_i),
    .rd_data_o  (rd_data_o),
    .status_o   (status_o),
    .rx_ready_i (rx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_clear_o (rx_clear_o),
    .tx_busy_i  (tx_busy_i),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         starts[$];
  logic       ovr;
  logic       exp_clr;
  int         cyc;
  int         fall_cyc;
  logic       saw_busy;
  logic       skip_gap;
  int         busy_left;
  logic       busy_stuck;
  int         hold_cfg;
  logic       prev_busy;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: update the model from this cycle's inputs, clock the DUT,
  // advance the transmitter model, then compare the registered outputs.
  task automatic tick();
    logic       cap;
    logic       ovr_set;
    logic       start_now;
    logic [7:0] exp_rd;
    start_now = 1'b0;
    if (tx_start_o === 1'b1) begin
      start_now = 1'b1;
      chk("tx_start_nonempty", 32'(txq.size() != 0), 32'd1);
      if (txq.size() != 0) chk("tx_data", 32'(tx_data_o), 32'(txq.pop_front()));
      if (saw_busy && !skip_gap) chk("tx_gap_after_busy", 32'((cyc - fall_cyc) >= 2), 32'd1);
      saw_busy = 1'b0;
      skip_gap = 1'b0;
      starts.push_back(cyc);
    end
    if (rst) begin
      rxq.delete();
      txq.delete();
      ovr      = 1'b0;
      exp_clr  = 1'b0;
      saw_busy = 1'b0;
      skip_gap = 1'b1;
    end else begin
      cap = rx_ready_i && !exp_clr;
      if (rd_req_i && rxq.size() != 0) void'(rxq.pop_front());
      ovr_set = 1'b0;
      if (cap) begin
        if (rxq.size() < DEPTH) rxq.push_back(rx_data_i);
        else ovr_set = 1'b1;
      end
      if (ovr_set) ovr = 1'b1;
      else if (stat_rd_i) ovr = 1'b0;
      exp_clr = cap;
      if (wr_req_i && txq.size() < DEPTH) txq.push_back(wr_data_i);
    end

    @(posedge clk_50M);
    #1;
    cyc++;
    rd_req_i  = 1'b0;
    wr_req_i  = 1'b0;
    stat_rd_i = 1'b0;
    rst       = 1'b0;

    if (start_now) begin
      if (hold_cfg < 0) busy_left = int'($urandom_range(0, 6));
      else busy_left = hold_cfg;
    end
    prev_busy = tx_busy_i;
    if (busy_stuck) begin
      tx_busy_i = 1'b1;
    end else if (busy_left > 0) begin
      tx_busy_i = 1'b1;
      busy_left--;
    end else begin
      tx_busy_i = 1'b0;
    end
    if (tx_busy_i) saw_busy = 1'b1;
    if (prev_busy && !tx_busy_i) fall_cyc = cyc;

    if (rxq.size() != 0) exp_rd = rxq[0];
    else exp_rd = 8'h00;
    chk("status", 32'(status_o),
        32'({ovr, 1'(rxq.size() != 0), 1'(txq.size() != DEPTH)}));
    chk("rd_data", 32'(rd_data_o), 32'(exp_rd));
    chk("rx_clear", 32'(rx_clear_o), 32'(exp_clr));
  endtask

  task automatic drain_tx();
    for (int i = 0; i < 600 && txq.size() != 0; i++) tick();
    chk("tx_drained", 32'(txq.size()), 32'd0);
    repeat (20) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int tcyc;
    int s0;
    n_checks = 0; n_fail = 0;
    cyc = 0; fall_cyc = 0; saw_busy = 1'b0; skip_gap = 1'b1;
    busy_left = 0; busy_stuck = 1'b0; hold_cfg = 10; prev_busy = 1'b0;
    ovr = 1'b0; exp_clr = 1'b0;
    rst = 1'b1; rd_req_i = 1'b0; wr_req_i = 1'b0; wr_data_i = 8'h00;
    stat_rd_i = 1'b0; rx_ready_i = 1'b0; rx_data_i = 8'h00; tx_busy_i = 1'b0;

    // Reset state
    tick();
    rst = 1'b1;
    tick();
    chk("reset_status", 32'(status_o), 32'h1);
    chk("reset_rd_data", 32'(rd_data_o), 32'h0);
    chk("reset_tx_start", 32'(tx_start_o), 32'h0);
    chk("reset_rx_clear", 32'(rx_clear_o), 32'h0);
    chk("reset_tx_data", 32'(tx_data_o), 32'h0);

    // Single RX byte with ready held two cycles
    rx_ready_i = 1'b1; rx_data_i = 8'hA5;
    tick();
    chk("single_rd_data", 32'(rd_data_o), 32'hA5);
    chk("single_avail", 32'(status_o[1]), 32'h1);
    chk("single_clear_hi", 32'(rx_clear_o), 32'h1);
    tick();
    chk("single_clear_lo", 32'(rx_clear_o), 32'h0);
    rx_ready_i = 1'b0;
    rd_req_i = 1'b1;
    tick();
    chk("single_empty", 32'(status_o[1]), 32'h0);
    rd_req_i = 1'b1;
    tick();
    chk("pop_empty_ignored", 32'(status_o), 32'h1);

    // RX overflow, no reads
    for (int i = 0; i < 17; i++) begin
      rx_ready_i = 1'b1; rx_data_i = 8'(i);
      tick();
      rx_ready_i = 1'b0;
      tick();
    end
    chk("ovf_overrun_set", 32'(status_o[2]), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", 32'(rd_data_o), 32'(i));
      rd_req_i = 1'b1;
      tick();
    end
    chk("ovf_empty", 32'(status_o[1]), 32'h0);
    chk("ovf_overrun_sticky", 32'(status_o[2]), 32'h1);
    stat_rd_i = 1'b1;
    tick();
    chk("ovf_overrun_clr", 32'(status_o[2]), 32'h0);

    // RX overflow with a coincident read on the 17th byte
    for (int i = 0; i < 16; i++) begin
      rx_ready_i = 1'b1; rx_data_i = 8'(i);
      tick();
      rx_ready_i = 1'b0;
      tick();
    end
    rx_ready_i = 1'b1; rx_data_i = 8'h10; rd_req_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    tick();
    chk("ovf2_no_overrun", 32'(status_o[2]), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf2_order", 32'(rd_data_o), 32'(i));
      rd_req_i = 1'b1;
      tick();
    end
    chk("ovf2_empty", 32'(status_o[1]), 32'h0);

    // TX ordering with a 10-cycle busy
    hold_cfg = 10;
    s0 = starts.size();
    tcyc = cyc;
    wr_req_i = 1'b1; wr_data_i = 8'h31; tick();
    wr_req_i = 1'b1; wr_data_i = 8'h32; tick();
    wr_req_i = 1'b1; wr_data_i = 8'h33; tick();
    drain_tx();
    chk("tx_order_count", 32'(starts.size() - s0), 32'd3);
    if (starts.size() - s0 >= 3) begin
      chk("tx_first_latency", 32'(starts[s0] - tcyc), 32'd2);
      chk("tx_spacing_1", 32'(starts[s0+1] - starts[s0]), 32'd13);
      chk("tx_spacing_2", 32'(starts[s0+2] - starts[s0+1]), 32'd13);
    end

    // TX full with busy stuck high behind a primer byte
    busy_stuck = 1'b1; tx_busy_i = 1'b1;
    s0 = starts.size();
    wr_req_i = 1'b1; wr_data_i = 8'hC0; tick();
    repeat (4) tick();
    chk("txfull_primer_sent", 32'(starts.size() - s0), 32'd1);
    for (int i = 0; i < 17; i++) begin
      wr_req_i = 1'b1; wr_data_i = 8'(8'h40 + i);
      tick();
      if (i == 14) chk("txfull_space_15", 32'(status_o[0]), 32'h1);
      if (i == 15) chk("txfull_space_16", 32'(status_o[0]), 32'h0);
    end
    chk("txfull_space_17", 32'(status_o[0]), 32'h0);
    busy_stuck = 1'b0; hold_cfg = 2;
    s0 = starts.size();
    drain_tx();
    chk("txfull_sent", 32'(starts.size() - s0), 32'd16);

    // Transmitter that never raises busy: timeout path
    hold_cfg = 0;
    s0 = starts.size();
    tcyc = cyc;
    wr_req_i = 1'b1; wr_data_i = 8'h61; tick();
    wr_req_i = 1'b1; wr_data_i = 8'h62; tick();
    wr_req_i = 1'b1; wr_data_i = 8'h63; tick();
    drain_tx();
    chk("timeout_count", 32'(starts.size() - s0), 32'd3);
    if (starts.size() - s0 >= 3) begin
      chk("timeout_first", 32'(starts[s0] - tcyc), 32'd2);
      chk("timeout_spacing_1", 32'(starts[s0+1] - starts[s0]), 32'd7);
      chk("timeout_spacing_2", 32'(starts[s0+2] - starts[s0+1]), 32'd7);
    end

    // Randomized traffic against the model
    hold_cfg = -1;
    for (int i = 0; i < 800; i++) begin
      rx_ready_i = ($urandom_range(0, 2) == 0);
      rx_data_i  = 8'($urandom);
      if (i < 400) rd_req_i = ($urandom_range(0, 7) == 0);
      else rd_req_i = ($urandom_range(0, 1) == 0);
      stat_rd_i = ($urandom_range(0, 15) == 0);
      wr_req_i  = (txq.size() < 6) && ($urandom_range(0, 4) == 0);
      wr_data_i = 8'($urandom);
      rst       = ($urandom_range(0, 249) == 0);
      tick();
    end
    rx_ready_i = 1'b0;
    hold_cfg = 2;
    drain_tx();

    // Reset with 5 bytes queued in TX and 3 in RX
    busy_stuck = 1'b1; tx_busy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_req_i = 1'b1; wr_data_i = 8'(8'hD0 + i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      rx_ready_i = 1'b1; rx_data_i = 8'(8'hE0 + i);
      tick();
      rx_ready_i = 1'b0;
      tick();
    end
    chk("pre_reset_status", 32'(status_o), 32'h3);
    chk("pre_reset_rd_data", 32'(rd_data_o), 32'hE0);
    rst = 1'b1;
    tick();
    chk("midrst_status", 32'(status_o), 32'h1);
    chk("midrst_rd_data", 32'(rd_data_o), 32'h0);
    chk("midrst_tx_start", 32'(tx_start_o), 32'h0);
    busy_stuck = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("midrst_no_start", 32'(tx_start_o), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_bridge.md
# uart_fifo_bridge

Byte-buffering bridge between the CPU-side memory/serial address decoder and the `async_receiver` / `async_transmitter` pair. It holds received bytes in an RX FIFO and queued outgoing bytes in a TX FIFO. This lets software poll `SerialStat` and access `SerialDate` without losing bytes at 9600 baud. It drives the transmitter through a start/busy handshake state machine and clears the receiver's ready flag after every capture.

## Interface
- DEPTH, 16, entries per FIFO; power of two, minimum 2.
- AW, 4, log2(DEPTH); occupancy counters are AW+1 bits.
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- rd_req_i  in  1  one-cycle pulse: pop RX FIFO (CPU read of SerialDate).
- wr_req_i  in  1  one-cycle pulse: push wr_data_i into TX FIFO (CPU write of SerialDate).
- wr_data_i  in  8  byte to transmit.
- stat_rd_i  in  1  one-cycle pulse: CPU read of SerialStat; clears overrun.
- rd_data_o  out  8  RX FIFO head (show-ahead); 8'h00 when RX empty.
- status_o  out  3  {overrun, rx_avail, tx_space}; bit0 = TX not full, bit1 = RX not empty.
- rx_ready_i  in  1  receiver byte-ready flag (level, held until cleared).
- rx_data_i  in  8  receiver byte.
- rx_clear_o  out  1  one-cycle clear pulse to the receiver.
- tx_busy_i  in  1  transmitter busy.
- tx_start_o  out  1  one-cycle transmitter start.
- tx_data_o  out  8  byte presented with tx_start_o; held until the next start.

## Operation
- Reset values: all pointers and counts 0; overrun 0; FSM in IDLE; rx_clear_o = 0; tx_start_o = 0; tx_data_o = 8'h00; therefore status_o = 3'b001 and rd_data_o = 8'h00.
- RX capture:
  - A byte is captured when rx_ready_i = 1 and rx_clear_o = 0 in the same cycle.
  - On capture, rx_clear_o is registered high for exactly the next cycle. This guard prevents a double capture while the receiver's flag is still falling.
  - If RX is not full, the byte is pushed.
  - If RX is full and rd_req_i is low, the byte is dropped and overrun is set to 1. The clear pulse is still issued.
  - If RX is full and rd_req_i is high in the same cycle, the pop and push both happen. There is no overrun and the count stays at DEPTH.
- RX pop: rd_req_i while RX is empty is ignored; the count never underflows. A simultaneous push and pop leaves the count unchanged.
- Overrun: sticky; cleared by stat_rd_i. If stat_rd_i and a new overrun occur in the same cycle, set wins.
- TX push: wr_req_i while TX is full is dropped silently; software must poll tx_space. A push in the same cycle as an FSM pop is allowed when full: the pop frees a slot.
- TX FSM:
  - IDLE: when TX is not empty, go to START.
  - START: pop the head into tx_data_o; tx_start_o = 1 for this cycle only; go to WAIT_BUSY.
  - WAIT_BUSY: when tx_busy_i = 1, go to WAIT_DONE. Otherwise a 2-bit counter advances, and on the 4th cycle without busy the FSM goes to WAIT_DONE regardless (anti-deadlock).
  - WAIT_DONE: when tx_busy_i = 0, go to IDLE.
- Pointers: AW-bit pointers, wrapping from DEPTH-1 to 0. Full means count == DEPTH; empty means count == 0.
- Reset mid-operation: rst wins over every other event in that cycle. Both FIFOs are flushed and the FSM returns to IDLE. A byte already being shifted by the transmitter is not aborted.

## Timing
- RX latency: rx_ready_i rises in cycle c → the byte is visible on rd_data_o and status_o[1] = 1 in cycle c+1; rx_clear_o is high in cycle c+1.
- rd_req_i in cycle c → rd_data_o shows the next entry (or 8'h00) in cycle c+1.
- TX latency: wr_req_i in cycle t with TX empty and the FSM in IDLE → tx_start_o is high in cycle t+2, with tx_data_o valid in that same cycle.
- Back-to-back bytes: the next tx_start_o comes no earlier than 2 cycles after tx_busy_i falls.
- status_o is fully registered-state derived; no combinational path from inputs.
- Throughput: one RX capture per 2 cycles at most, far above the line rate.

## Test plan
- Reset with all inputs at 0 → status_o = 3'b001, rd_data_o = 8'h00, tx_start_o = 0, rx_clear_o = 0.
- Single RX byte: rx_data_i = 8'hA5, with rx_ready_i held for 2 cycles → exactly one push; rx_clear_o is a single pulse; rd_data_o = 8'hA5 and status_o[1] = 1; after rd_req_i, status_o[1] = 0.
- RX overflow: push 17 bytes 8'h00..8'h10 with no reads → the first 16 are read back in order; 8'h10 is lost; status_o[2] = 1 until stat_rd_i, then 0. Repeat with rd_req_i coincident with the 17th byte → no overrun, and 8'h10 is retained.
- TX ordering: write 8'h31, 8'h32, 8'h33 back-to-back, with a model transmitter raising busy 1 cycle after start and holding it 10 cycles → three tx_start_o pulses carrying 31/32/33, each issued only after busy has fallen; the first pulse arrives 2 cycles after the first wr_req_i.
- TX full: 17 writes with tx_busy_i stuck at 1 → status_o[0] = 0 once 16 bytes are queued; the 17th write is dropped; once busy is released, exactly 16 bytes go out. Separately, busy never asserting → FSM timeout, and each byte still goes out in order.
- Reset mid-transfer: assert rst with 5 bytes queued in TX and 3 in RX → on the next cycle both FIFOs are empty, status_o = 3'b001, and no further tx_start_o occurs.
